// File: rtl/prog_loader_pkg.sv
// Shared constants for the serial program loader: sync byte, FSM state codes, byte-index width.
package prog_loader_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int BIDX_W = 2;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_CNT_HI = 3'd1;
  localparam state_t S_CNT_LO = 3'd2;
  localparam state_t S_WORD   = 3'd3;
  localparam state_t S_CSUM   = 3'd4;
  localparam state_t S_ERROR  = 3'd5;
endpackage

// File: rtl/prog_loader_if.sv
// Instruction RAM write port plus loader status, driven by prog_loader (master).
interface prog_loader_if #(parameter int ADDR_W = 11);
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  modport master (output wen, waddr, wdata, cpu_hold, load_done, load_err);
  modport slave  (input  wen, waddr, wdata, cpu_hold, load_done, load_err);
endinterface

// File: rtl/prog_loader_uart_rx_byte.sv
// 8N1 UART byte receiver with 2-flop synchroniser, mid-bit start re-check and stop-bit framing check.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 139
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       ferr
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  logic          rx_m, rx_s, rx_q;
  logic [1:0]    st;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // sync chain resets to the idle-high level so reset release never looks like a start bit
      rx_m  <= 1'b1;
      rx_s  <= 1'b1;
      rx_q  <= 1'b1;
      st    <= R_IDLE;
      cnt   <= '0;
      bitn  <= '0;
      data  <= '0;
      valid <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      rx_m  <= rx;
      rx_s  <= rx_m;
      rx_q  <= rx_s;
      valid <= 1'b0;
      ferr  <= 1'b0;
      case (st)
        R_IDLE:
          if (rx_q && !rx_s) begin
            st  <= R_START;
            cnt <= '0;
          end
        R_START:
          if (cnt == HALF) begin
            cnt  <= '0;
            bitn <= '0;
            st   <= rx_s ? R_IDLE : R_DATA;
          end else cnt <= cnt + 1'b1;
        R_DATA:
          if (cnt == LAST) begin
            cnt  <= '0;
            data <= {rx_s, data[7:1]};
            bitn <= bitn + 1'b1;
            if (bitn == 3'd7) st <= R_STOP;
          end else cnt <= cnt + 1'b1;
        R_STOP:
          if (cnt == LAST) begin
            st    <= R_IDLE;
            valid <= rx_s;
            ferr  <= !rx_s;
          end else cnt <= cnt + 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/prog_loader.sv
// Framed UART program loader writing 32-bit words into instruction RAM; holds the CPU while loading.
// Optional trailing checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int CLKS_PER_BIT = 139,
  parameter int ADDR_W       = 11,
  parameter int DEPTH        = 2048,
  parameter int TIMEOUT_CLKS = 16000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx,
  prog_loader_if.master bus
);
  import prog_loader_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  logic [7:0]        rx_data;
  logic              rx_vld, rx_ferr;
  state_t            state;
  logic [15:0]       cnt, widx;
  logic [BIDX_W-1:0] bidx;
  logic [23:0]       wbuf;
  logic [TW-1:0]     tmo;
  logic [15:0]       count_lo, widx_nxt;
  logic              timeout;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .data  (rx_data),
    .valid (rx_vld),
    .ferr  (rx_ferr)
  );

  assign count_lo = {cnt[15:8], rx_data};
  assign widx_nxt = widx + 16'd1;
  assign timeout  = (state != S_IDLE) && (state != S_ERROR) && (tmo == TW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      widx          <= '0;
      bidx          <= '0;
      wbuf          <= '0;
      tmo           <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
      bus.wen       <= 1'b0;
      bus.waddr     <= '0;
      bus.wdata     <= '0;
      bus.cpu_hold  <= 1'b0;
      bus.load_done <= 1'b0;
      bus.load_err  <= 1'b0;
    end else begin
      bus.wen       <= 1'b0;
      bus.load_done <= 1'b0;
      if (state == S_IDLE || state == S_ERROR || rx_vld) tmo <= '0;
      else tmo <= tmo + 1'b1;

      case (state)
        S_IDLE:
          if (rx_vld && rx_data == SYNC_BYTE) begin
            state        <= S_CNT_HI;
            bus.cpu_hold <= 1'b1;
            bus.load_err <= 1'b0;
            bus.waddr    <= '0;
            widx         <= '0;
            bidx         <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
          end
        // CPU_HOLD is left asserted: the RAM image is incomplete
        S_ERROR: begin
          bus.load_err <= 1'b1;
          state        <= S_IDLE;
        end
        default:
          if (rx_ferr || timeout) state <= S_ERROR;
          else if (rx_vld) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            csum <= csum + rx_data;
`endif
            case (state)
              S_CNT_HI: begin
                cnt[15:8] <= rx_data;
                state     <= S_CNT_LO;
              end
              S_CNT_LO: begin
                cnt[7:0] <= rx_data;
                if (17'(count_lo) > 17'(DEPTH)) state <= S_ERROR;
                else if (count_lo == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                  state <= S_CSUM;
`else
                  state         <= S_IDLE;
                  bus.load_done <= 1'b1;
                  bus.cpu_hold  <= 1'b0;
`endif
                end else state <= S_WORD;
              end
              S_WORD: begin
                bidx <= bidx + 1'b1;
                wbuf <= {wbuf[15:0], rx_data};
                if (bidx == BIDX_W'(3)) begin
                  bus.wen   <= 1'b1;
                  bus.wdata <= {wbuf, rx_data};
                  bus.waddr <= widx[ADDR_W-1:0];
                  widx      <= widx_nxt;
                  if (widx_nxt == cnt) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state <= S_CSUM;
`else
                    state         <= S_IDLE;
                    bus.load_done <= 1'b1;
                    bus.cpu_hold  <= 1'b0;
`endif
                  end
                end
              end
`ifdef PROG_LOADER_CHECKSUM_EN
              S_CSUM:
                if (rx_data == csum) begin
                  state         <= S_IDLE;
                  bus.load_done <= 1'b1;
                  bus.cpu_hold  <= 1'b0;
                end else state <= S_ERROR;
`endif
              default: state <= S_ERROR;
            endcase
          end
      endcase
    end
  end
endmodule
